// File: rtl/xoro_pkg.sv
// Shared definitions for the xoro SoC peripherals: register offsets, status bits,
// transmitter FSM encoding and the baud divisor floor.
// No logic; imported by uart_tx and its testbench-visible interface users.
package xoro_pkg;

    // Word offsets decoded from mem_addr[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    // STATUS register bit positions
    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_ACTIVE = 2;

    // Smallest usable clocks-per-bit value
    localparam logic [15:0] MIN_BAUDDIV = 16'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < MIN_BAUDDIV) ? MIN_BAUDDIV : div;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// picorv32 native memory bus as seen by one responder, plus its decoder select.
// No latency of its own; master = CPU side, slave = peripheral side.
// mem_ready is a one-cycle acknowledge; mem_rdata is only meaningful while it is high.
interface uart_tx_if;
    logic        enable;
    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with show-ahead read port (pop_dat valid while !empty).
// Latency: a push is visible at pop_dat one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full/empty.
// Ports: clk, reset (sync, active-high), push/push_dat, pop/pop_dat, full, empty.
// Only compiled when UART_TX_FIFO_EN selects the FIFO build of uart_tx.
`ifdef UART_TX_FIFO_EN
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule
`endif

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus (TXDATA/STATUS/BAUDDIV).
// Latency: ack and read data one cycle after a selected request; tx falls 2 edges after a push into an idle block.
// Backpressure: a TXDATA write while storage is full is held unacknowledged until a slot frees; never dropped.
// Ports: clk, reset (sync, active-high), bus (uart_tx_if.slave), tx (serial out, idle high).
// Build option UART_TX_FIFO_EN: FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx
    import xoro_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     tx
);
    localparam logic [15:0] DIV_RESET = clamp_div(16'(CLK_FREQ / BAUD));

    // ---------------- bus decode ----------------
    logic [1:0]  reg_sel;
    logic        req;
    logic        push_req;
    logic        stall;
    logic        ack;
    logic        push;
    logic        div_wr;
    logic [15:0] bauddiv;
    logic [15:0] div_merged;
    logic [31:0] rdata_next;
    logic        active_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic [7:0]  pop_dat;

    assign reg_sel  = bus.mem_addr[3:2];
    // Excluding the ack cycle keeps a still-held request from being acknowledged twice
    assign req      = bus.mem_valid & bus.enable & ~bus.mem_ready;
    assign push_req = ~bus.mem_instr & (reg_sel == REG_TXDATA) & bus.mem_wstrb[0];
    assign stall    = push_req & fifo_full;
    assign ack      = req & ~stall;
    assign push     = ack & push_req;
    assign div_wr   = ack & ~bus.mem_instr & (reg_sel == REG_BAUDDIV) & (|bus.mem_wstrb[1:0]);

    always_comb begin
        div_merged = bauddiv;
        if (bus.mem_wstrb[0]) div_merged[7:0]  = bus.mem_wdata[7:0];
        if (bus.mem_wstrb[1]) div_merged[15:8] = bus.mem_wdata[15:8];
    end

    always_comb begin
        rdata_next = '0;
        if (ack && !bus.mem_instr && bus.mem_wstrb == 4'b0000) begin
            case (reg_sel)
                REG_STATUS: begin
                    rdata_next[STAT_FULL]   = fifo_full;
                    rdata_next[STAT_EMPTY]  = fifo_empty;
                    rdata_next[STAT_ACTIVE] = active_q;
                end
                REG_BAUDDIV: rdata_next[15:0] = bauddiv;
                default:     rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            bauddiv       <= DIV_RESET;
        end else begin
            bus.mem_ready <= ack;
            bus.mem_rdata <= rdata_next;
            if (div_wr) bauddiv <= clamp_div(div_merged);
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.mem_wdata[31:16], bus.mem_addr[31:4], bus.mem_addr[1:0]};

    // ---------------- transmit storage ----------------
`ifdef UART_TX_FIFO_EN
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (bus.mem_wdata[7:0]),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
`else
    logic       hold_vld;
    logic [7:0] hold_dat;
    logic       unused_depth;

    assign unused_depth = (FIFO_DEPTH != 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else if (push) begin
            hold_vld <= 1'b1;
            hold_dat <= bus.mem_wdata[7:0];
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign fifo_full  = hold_vld;
    assign fifo_empty = ~hold_vld;
    assign pop_dat    = hold_dat;
`endif

    // ---------------- transmit FSM ----------------
    tx_state_t   state;
    tx_state_t   state_next;
    logic [15:0] baud_cnt;
    logic [15:0] div_lat;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tick;
    logic        tx_next;

    assign tick = (baud_cnt == 16'd0);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = 1'b1;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (tick) state_next = DATA;
            end
            DATA: begin
                tx_next = shreg[bit_idx];
                if (tick && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                // Chain straight into the next start bit when more data is waiting
                if (tick) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx and ACTIVE are registered so both line up with the bit actually on the wire
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            div_lat  <= MIN_BAUDDIV;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state    <= state_next;
            tx       <= tx_next;
            active_q <= (state != IDLE);
            if (pop) begin
                // Divisor is sampled once per frame so mid-frame writes wait for the next frame
                shreg    <= pop_dat;
                div_lat  <= bauddiv;
                baud_cnt <= bauddiv - 16'd1;
                bit_idx  <= '0;
            end else if (state != IDLE) begin
                if (tick) begin
                    baud_cnt <= div_lat - 16'd1;
                    if (state == DATA) bit_idx <= bit_idx + 3'd1;
                end else begin
                    baud_cnt <= baud_cnt - 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: randomized bus traffic against a queue-based line model.
// Serial output is checked sample-by-sample against ideal 8N1 frames.
// Storage capacity follows the same UART_TX_FIFO_EN build option as the design.
module tb_uart_tx;
    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx;

    uart_tx_if bus();

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    int         model_div = CLK_FREQ / BAUD;
    int         ack_cyc   = 0;

    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input logic instr,
                            output logic [31:0] rdata, output int lat);
        logic [15:0] d;
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_instr = instr;
        bus.mem_wstrb = wstrb;
        bus.mem_wdata = wdata;
        bus.mem_addr  = addr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.mem_ready && lat < 5000);
        rdata   = bus.mem_rdata;
        ack_cyc = cyc;
        check("ack", bus.mem_ready, 1'b1);
        if (bus.mem_ready && !instr) begin
            if (addr[3:2] == 2'd0 && wstrb[0]) exp_q.push_back(wdata[7:0]);
            if (addr[3:2] == 2'd2 && (wstrb[0] || wstrb[1])) begin
                d = 16'(model_div);
                if (wstrb[0]) d[7:0]  = wdata[7:0];
                if (wstrb[1]) d[15:8] = wdata[15:8];
                model_div = (d < 16'd2) ? 2 : int'(d);
            end
        end
        bus.mem_valid = 1'b0;
        bus.enable    = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_wstrb = 4'b0000;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb, output int lat);
        logic [31:0] unused_r;
        bus_xfer(addr, wstrb, wdata, 1'b0, unused_r, lat);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] rdata);
        int lat;
        bus_xfer(addr, 4'b0000, 32'h0, 1'b0, rdata, lat);
    endtask

    // ---------------- line monitor ----------------
    bit         in_frame     = 0;
    int         fidx         = 0;
    int         fdiv         = 2;
    int         ferr         = 0;
    int         frame_cnt    = 0;
    int         frame_start  = 0;
    int         idle_run     = 0;
    int         gap_max      = 0;
    int         burst_frames = 0;
    logic [7:0] fexp;
    logic [7:0] fobs;

    initial begin
        int   b;
        logic expbit;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame = 0;
                idle_run = 0;
            end else begin
                if (!in_frame) begin
                    if (tx === 1'b0) begin
                        check("frame_expected", exp_q.size() != 0, 1'b1);
                        fexp        = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                        fdiv        = model_div;
                        fidx        = 0;
                        ferr        = 0;
                        fobs        = 8'h00;
                        in_frame    = 1;
                        frame_start = cyc;
                        frame_cnt++;
                        if (burst_frames > 0 && idle_run > gap_max) gap_max = idle_run;
                        burst_frames++;
                        idle_run = 0;
                    end else begin
                        idle_run++;
                    end
                end
                if (in_frame) begin
                    b      = fidx / fdiv;
                    expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : fexp[b-1];
                    if (tx !== expbit) ferr++;
                    if (b >= 1 && b <= 8 && (fidx % fdiv) == fdiv / 2) fobs[b-1] = tx;
                    fidx++;
                    if (fidx == 10 * fdiv) begin
                        in_frame = 0;
                        check("frame_byte", fobs, fexp);
                        check("frame_shape_errs", ferr, 0);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain", (exp_q.size() == 0 && !in_frame), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_frame_pos(input int k);
        int n = 0;
        while (!(in_frame && fidx >= k) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("frame_pos_reached", (in_frame && fidx >= k), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        int          lat;
        int          fc;
        int          n;
        logic [7:0]  byt;

        bus.enable    = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_wstrb = 4'b0000;
        bus.mem_wdata = 32'h0;
        bus.mem_addr  = 32'h0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", bus.mem_ready, 1'b0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        reset = 1'b0;

        // STATUS after reset, read latency
        bus_xfer(32'h4, 4'b0000, 32'h0, 1'b0, r, lat);
        check("status_reset", r, 32'h2);
        check("read_latency", lat, 1);
        rd(32'h8, r);
        check("bauddiv_reset", r, 32'(model_div));

        // Request held through its ack cycle must not be acknowledged back-to-back
        @(negedge clk);
        bus.enable = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = 32'h4; bus.mem_wstrb = 4'b0000;
        @(negedge clk);
        check("held_first_ack", bus.mem_ready, 1'b1);
        @(negedge clk);
        check("held_no_double_ack", bus.mem_ready, 1'b0);
        // Not selected: no ack, rdata stays zero
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        check("unselected_ready", bus.mem_ready, 1'b0);
        check("unselected_rdata", bus.mem_rdata, 32'h0);
        bus.mem_valid = 1'b0;

        // BAUDDIV clamp and byte strobes
        wr(32'h8, 32'h0, 4'b0011, lat);
        rd(32'h8, r);
        check("bauddiv_clamp", r, 32'h2);
        wr(32'h8, 32'h0000_1234, 4'b0011, lat);
        wr(32'h8, 32'hFFFF_AB99, 4'b0010, lat);
        rd(32'h8, r);
        check("bauddiv_strobe", r, 32'h0000_AB34);
        check("bauddiv_model", r, 32'(model_div));
        wr(32'hC, 32'hFFFF_FFFF, 4'b1111, lat);
        rd(32'h8, r);
        check("reserved_write_ignored", r, 32'h0000_AB34);
        rd(32'hC, r);
        check("reserved_read", r, 32'h0);
        rd(32'h0, r);
        check("txdata_read", r, 32'h0);
        bus_xfer(32'h8, 4'b0000, 32'h0, 1'b1, r, lat);
        check("instr_fetch_rdata", r, 32'h0);

        // Single frame, div 4
        wr(32'h8, 32'd4, 4'b0011, lat);
        fc = frame_cnt;
        wr(32'h0, 32'h55, 4'b0001, lat);
        n = 0;
        while (frame_cnt == fc && n < 100) begin @(negedge clk); n++; end
        check("tx_fall_after_ack", frame_start - ack_cyc, 2);
        rd(32'h4, r);
        check("status_active", r, 32'h6);
        wait_idle();
        rd(32'h4, r);
        check("status_done", r, 32'h2);

        // Burst beyond capacity: last write stalls until the second frame starts
        wr(32'h8, 32'd3, 4'b0011, lat);
        gap_max = 0;
        burst_frames = 0;
        for (int i = 0; i < CAP + 2; i++) begin
            wr(32'h0, 32'($urandom_range(0, 255)), 4'b0001, lat);
            if (i < CAP + 1) check("burst_no_stall", lat, 1);
            else             check("burst_stalled", lat > 1, 1'b1);
        end
        @(negedge clk);
        check("stall_release_cycle", ack_cyc, frame_start);
        wait_idle();
        check("burst_frame_count", burst_frames, CAP + 2);
        check("burst_contiguous", gap_max, 0);

        // Divisor change mid-frame applies to the next frame only
        wr(32'h8, 32'd4, 4'b0011, lat);
        wr(32'h0, 32'($urandom_range(0, 255)), 4'b0001, lat);
        wr(32'h0, 32'($urandom_range(0, 255)), 4'b0001, lat);
        wait_frame_pos(12);
        rd(32'h4, r);
        check("status_busy", r, (CAP == 1) ? 32'h5 : 32'h4);
        wr(32'h8, 32'd8, 4'b0011, lat);
        rd(32'h8, r);
        check("bauddiv_midframe", r, 32'd8);
        wait_idle();

        // Random rounds
        for (int k = 0; k < 3; k++) begin
            wr(32'h8, 32'($urandom_range(2, 6)), 4'b0011, lat);
            n = $urandom_range(1, CAP + 1);
            for (int i = 0; i < n; i++) begin
                byt = 8'($urandom_range(0, 255));
                wr(32'h0, {24'h0, byt}, 4'b0001, lat);
            end
            wait_idle();
        end

        // Reset in the middle of a frame with data queued
        wr(32'h8, 32'd4, 4'b0011, lat);
        wr(32'h0, 32'hA3, 4'b0001, lat);
        for (int i = 0; i < ((CAP < 3) ? CAP : 3); i++)
            wr(32'h0, 32'($urandom_range(0, 255)), 4'b0001, lat);
        wait_frame_pos(10);
        reset = 1'b1;
        @(negedge clk);
        check("reset_tx_high", tx, 1'b1);
        exp_q.delete();
        model_div = CLK_FREQ / BAUD;
        @(negedge clk);
        reset = 1'b0;
        fc = frame_cnt;
        rd(32'h4, r);
        check("status_after_reset", r, 32'h2);
        repeat (100) @(negedge clk);
        check("no_frames_after_reset", frame_cnt, fc);
        check("tx_idle_after_reset", tx, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
